// File: rtl/scgra_ctrl_pkg.sv
// Shared types and defaults for the SCGRA run controller.
package scgra_ctrl_pkg;

  localparam int DEF_IADDR_WIDTH  = 10;
  localparam int DEF_FILL_CYCLES  = 2;
  localparam int DEF_DRAIN_CYCLES = 4;

  // Buffer-port mux select encodings
  localparam logic BUF_SEL_HOST = 1'b0;
  localparam logic BUF_SEL_PE   = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } run_state_e;

endpackage

// File: rtl/scgra_perf_counter.sv
// Saturating 32-bit run-length performance counter.
module scgra_perf_counter (
  input  logic        gclk,
  input  logic        grst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] cnt
);

  // Clear wins over increment; hold at all-ones once reached
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)                cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + 32'd1;
  end

endmodule

// File: rtl/scgra_run_ctrl.sv
// Run controller and buffer-port arbiter for the 5x5 SCGRA torus.
// Optional feature: define SCGRA_PERF_CNT_EN to build the run-cycle counter.
module scgra_run_ctrl
  import scgra_ctrl_pkg::*;
#(
  parameter int IADDR_WIDTH  = DEF_IADDR_WIDTH,
  parameter int FILL_CYCLES  = DEF_FILL_CYCLES,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic                   Clk,
  input  logic                   Resetn,
  input  logic                   Start,
  input  logic                   Abort,
  input  logic [IADDR_WIDTH-1:0] Run_Len,
  input  logic                   Host_Req,
  output logic                   Host_Gnt,
  output logic                   Buf_Sel,
  output logic [IADDR_WIDTH-1:0] Inst_Addr,
  output logic                   PE_Array_Busy,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Aborted,
  output logic [31:0]            Run_Cycles
);

  run_state_e             state, state_nxt;
  logic [IADDR_WIDTH-1:0] ph_cnt;     // cycles spent in the current state
  logic [IADDR_WIDTH-1:0] run_len_q;
  logic [IADDR_WIDTH-1:0] run_last;
  logic                   start_acc;
  logic                   abort_acc;

  assign start_acc = Start && (state == IDLE);
  assign abort_acc = Abort && (state inside {FILL, RUN});
  assign run_last  = run_len_q - IADDR_WIDTH'(1);

  // Host owns the ports only while idle; a same-cycle Start takes them away
  assign Host_Gnt = Host_Req && (state == IDLE) && !Start;

  // State register
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state: phase lengths come from ph_cnt; Abort short-cuts to DRAIN
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (Start) state_nxt = (Run_Len == '0) ? DONE : FILL;
      FILL:  if (Abort)                                         state_nxt = DRAIN;
             else if (ph_cnt == IADDR_WIDTH'(FILL_CYCLES - 1))  state_nxt = RUN;
      RUN:   if (Abort)                                         state_nxt = DRAIN;
             else if (ph_cnt == run_last)                       state_nxt = DRAIN;
      DRAIN: if (ph_cnt == IADDR_WIDTH'(DRAIN_CYCLES - 1))      state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Phase counter, run length latch and instruction address
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      ph_cnt    <= '0;
      run_len_q <= '0;
      Inst_Addr <= '0;
    end else begin
      if (state_nxt != state || state == IDLE) ph_cnt <= '0;
      else                                      ph_cnt <= ph_cnt + IADDR_WIDTH'(1);
      if (start_acc) run_len_q <= Run_Len;
      // Address advances through FILL/RUN and parks on the last instruction
      if (state_nxt == IDLE)
        Inst_Addr <= '0;
      else if ((state inside {FILL, RUN}) && Inst_Addr != run_last)
        Inst_Addr <= Inst_Addr + IADDR_WIDTH'(1);
    end
  end

  // Registered status outputs decoded from the upcoming state
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      PE_Array_Busy <= 1'b0;
      Busy          <= 1'b0;
      Done          <= 1'b0;
      Buf_Sel       <= BUF_SEL_HOST;
      Aborted       <= 1'b0;
    end else begin
      PE_Array_Busy <= (state_nxt == RUN);
      Busy          <= (state_nxt != IDLE);
      Done          <= (state_nxt == DONE);
      Buf_Sel       <= (state_nxt inside {FILL, RUN, DRAIN}) ? BUF_SEL_PE : BUF_SEL_HOST;
      if (start_acc)      Aborted <= 1'b0;
      else if (abort_acc) Aborted <= 1'b1;
    end
  end

`ifdef SCGRA_PERF_CNT_EN
  // Busy already spans FILL..DONE, so the count freezes naturally in IDLE
  scgra_perf_counter u_perf (
    .gclk   (Clk),
    .grst_n (Resetn),
    .clr    (start_acc),
    .inc    (Busy),
    .cnt    (Run_Cycles)
  );
`else
  assign Run_Cycles = '0;
`endif

endmodule

// File: tb/tb_scgra_run_ctrl.sv
// Directed self-checking bench for scgra_run_ctrl (default parameters).
module tb_scgra_run_ctrl;

  localparam int W = 10;
`ifdef SCGRA_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic         Clk = 1'b0, Resetn = 1'b0, Start = 1'b0, Abort = 1'b0, Host_Req = 1'b0;
  logic [W-1:0] Run_Len = '0;
  logic         Host_Gnt, Buf_Sel, PE_Array_Busy, Busy, Done, Aborted;
  logic [W-1:0] Inst_Addr;
  logic [31:0]  Run_Cycles;

  int checks = 0;
  int errors = 0;

  scgra_run_ctrl dut (
    .Clk(Clk), .Resetn(Resetn), .Start(Start), .Abort(Abort), .Run_Len(Run_Len),
    .Host_Req(Host_Req), .Host_Gnt(Host_Gnt), .Buf_Sel(Buf_Sel), .Inst_Addr(Inst_Addr),
    .PE_Array_Busy(PE_Array_Busy), .Busy(Busy), .Done(Done), .Aborted(Aborted),
    .Run_Cycles(Run_Cycles)
  );

  always #5 Clk = ~Clk;

  // Advance one cycle and settle just after the edge
  task automatic tick;
    @(posedge Clk); #1;
  endtask

  task automatic test_reset;
    Resetn = 1'b0;
    tick; tick;
    checks++; if ({PE_Array_Busy, Busy, Done, Aborted, Buf_Sel, Host_Gnt} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 000000",
                         {PE_Array_Busy, Busy, Done, Aborted, Buf_Sel, Host_Gnt}); end
    checks++; if (Inst_Addr !== '0) begin
      errors++; $display("FAIL reset_addr got %0d exp 0", Inst_Addr); end
    checks++; if (Run_Cycles !== 32'd0) begin
      errors++; $display("FAIL reset_cycles got %0d exp 0", Run_Cycles); end
    Resetn = 1'b1;
    tick;
  endtask

  // Run_Len=5: FILL k1-2, RUN k3-7, DRAIN k8-11, DONE k12, IDLE k13
  task automatic test_nominal;
    bit e_pe, e_done, e_buf, e_busy;
    int e_addr;
    Run_Len = 10'd5; Start = 1'b1;
    tick; Start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      e_pe = (k >= 3 && k <= 7); e_done = (k == 12);
      e_buf = (k <= 11); e_busy = (k <= 12);
      e_addr = (k == 13) ? 0 : ((k > 5) ? 4 : k - 1);
      checks++; if (PE_Array_Busy !== e_pe) begin
        errors++; $display("FAIL nom_pe k=%0d got %b exp %b", k, PE_Array_Busy, e_pe); end
      checks++; if (Done !== e_done) begin
        errors++; $display("FAIL nom_done k=%0d got %b exp %b", k, Done, e_done); end
      checks++; if (Buf_Sel !== e_buf) begin
        errors++; $display("FAIL nom_bufsel k=%0d got %b exp %b", k, Buf_Sel, e_buf); end
      checks++; if (Busy !== e_busy) begin
        errors++; $display("FAIL nom_busy k=%0d got %b exp %b", k, Busy, e_busy); end
      checks++; if (Inst_Addr !== W'(e_addr)) begin
        errors++; $display("FAIL nom_addr k=%0d got %0d exp %0d", k, Inst_Addr, e_addr); end
      if (k < 13) tick;
    end
    checks++; if (Run_Cycles !== (PERF ? 32'd12 : 32'd0)) begin
      errors++; $display("FAIL nom_cycles got %0d exp %0d", Run_Cycles, PERF ? 12 : 0); end
  endtask

  task automatic test_zero_len;
    Run_Len = 10'd0; Start = 1'b1;
    tick; Start = 1'b0;
    checks++; if ({Done, Busy, PE_Array_Busy, Buf_Sel} !== 4'b1100) begin
      errors++; $display("FAIL zero_k1 got %b exp 1100", {Done, Busy, PE_Array_Busy, Buf_Sel}); end
    tick;
    checks++; if ({Done, Busy, PE_Array_Busy, Buf_Sel} !== 4'b0000) begin
      errors++; $display("FAIL zero_k2 got %b exp 0000", {Done, Busy, PE_Array_Busy, Buf_Sel}); end
    checks++; if (Run_Cycles !== (PERF ? 32'd1 : 32'd0)) begin
      errors++; $display("FAIL zero_cycles got %0d exp %0d", Run_Cycles, PERF ? 1 : 0); end
  endtask

  // Abort sampled at the end of the 3rd RUN cycle (k=5): DRAIN k6-9, DONE k10
  task automatic test_abort;
    Run_Len = 10'd100; Start = 1'b1;
    tick; Start = 1'b0;
    repeat (4) tick;
    checks++; if (PE_Array_Busy !== 1'b1) begin
      errors++; $display("FAIL abort_pre_pe got %b exp 1", PE_Array_Busy); end
    Abort = 1'b1;
    tick; Abort = 1'b0;
    checks++; if ({PE_Array_Busy, Aborted, Buf_Sel} !== 3'b011) begin
      errors++; $display("FAIL abort_k6 got %b exp 011", {PE_Array_Busy, Aborted, Buf_Sel}); end
    for (int k = 6; k <= 12; k++) begin
      checks++; if (Done !== (k == 10)) begin
        errors++; $display("FAIL abort_done k=%0d got %b exp %b", k, Done, k == 10); end
      if (k >= 11) begin
        checks++; if ({Aborted, Busy} !== 2'b10) begin
          errors++; $display("FAIL abort_sticky k=%0d got %b exp 10", k, {Aborted, Busy}); end
      end
      if (k < 12) tick;
    end
    checks++; if (Run_Cycles !== (PERF ? 32'd10 : 32'd0)) begin
      errors++; $display("FAIL abort_cycles got %0d exp %0d", Run_Cycles, PERF ? 10 : 0); end
  endtask

  // Run_Len=2: DONE at k9, grant back at k10
  task automatic test_host_arb;
    Host_Req = 1'b1; #1;
    checks++; if (Host_Gnt !== 1'b1) begin
      errors++; $display("FAIL arb_idle got %b exp 1", Host_Gnt); end
    Run_Len = 10'd2; Start = 1'b1; #1;
    checks++; if (Host_Gnt !== 1'b0) begin
      errors++; $display("FAIL arb_start_wins got %b exp 0", Host_Gnt); end
    tick; Start = 1'b0;
    checks++; if ({Buf_Sel, Aborted} !== 2'b10) begin
      errors++; $display("FAIL arb_k1 got %b exp 10", {Buf_Sel, Aborted}); end
    for (int k = 1; k <= 10; k++) begin
      checks++; if (Host_Gnt !== (k == 10)) begin
        errors++; $display("FAIL arb_gnt k=%0d got %b exp %b", k, Host_Gnt, k == 10); end
      if (k < 10) tick;
    end
    Host_Req = 1'b0;
  endtask

  task automatic test_ignored;
    Run_Len = 10'd5; Start = 1'b1;
    tick; Start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      checks++; if ({PE_Array_Busy, Done} !== {(k >= 3 && k <= 7), (k == 12)}) begin
        errors++; $display("FAIL ign_run k=%0d got %b exp %b", k, {PE_Array_Busy, Done},
                           {(k >= 3 && k <= 7), (k == 12)}); end
      if (k == 11) begin
        checks++; if (Inst_Addr !== W'(4)) begin
          errors++; $display("FAIL ign_addr got %0d exp 4", Inst_Addr); end
      end
      if (k == 4) begin Start = 1'b1; Run_Len = 10'd20; end
      if (k == 5) Start = 1'b0;
      if (k < 13) tick;
    end
    Abort = 1'b1;
    tick; Abort = 1'b0;
    checks++; if ({Busy, Aborted, Buf_Sel} !== 3'b000) begin
      errors++; $display("FAIL ign_idle_abort got %b exp 000", {Busy, Aborted, Buf_Sel}); end
    Start = 1'b1; Abort = 1'b1; Run_Len = 10'd1;
    tick; Start = 1'b0; Abort = 1'b0;
    checks++; if ({Busy, Aborted, Buf_Sel} !== 3'b101) begin
      errors++; $display("FAIL ign_start_abort got %b exp 101", {Busy, Aborted, Buf_Sel}); end
    for (int k = 2; k <= 9; k++) begin
      tick;
      checks++; if (Done !== (k == 8)) begin
        errors++; $display("FAIL ign_len1_done k=%0d got %b exp %b", k, Done, k == 8); end
    end
  endtask

  task automatic test_reset_midrun;
    Run_Len = 10'd50; Start = 1'b1;
    tick; Start = 1'b0;
    repeat (4) tick;
    checks++; if (PE_Array_Busy !== 1'b1) begin
      errors++; $display("FAIL rst_pre_pe got %b exp 1", PE_Array_Busy); end
    #1 Resetn = 1'b0;
    #1;
    checks++; if ({PE_Array_Busy, Busy, Done, Aborted, Buf_Sel, Host_Gnt} !== 6'b0) begin
      errors++; $display("FAIL rst_async_flags got %b exp 000000",
                         {PE_Array_Busy, Busy, Done, Aborted, Buf_Sel, Host_Gnt}); end
    checks++; if ({Inst_Addr, Run_Cycles} !== '0) begin
      errors++; $display("FAIL rst_async_vals addr %0d cycles %0d exp 0 0", Inst_Addr, Run_Cycles); end
    tick; tick;
    Resetn = 1'b1;
    tick;
    Run_Len = 10'd3; Start = 1'b1;
    tick; Start = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      checks++; if ({PE_Array_Busy, Done} !== {(k >= 3 && k <= 5), (k == 10)}) begin
        errors++; $display("FAIL rst_rerun k=%0d got %b exp %b", k, {PE_Array_Busy, Done},
                           {(k >= 3 && k <= 5), (k == 10)}); end
      if (k < 11) tick;
    end
    checks++; if (Run_Cycles !== (PERF ? 32'd10 : 32'd0)) begin
      errors++; $display("FAIL rst_rerun_cycles got %0d exp %0d", Run_Cycles, PERF ? 10 : 0); end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_zero_len;
    test_abort;
    test_host_arb;
    test_ignored;
    test_reset_midrun;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
